// File: rtl/ctrl_unit_gen2.sv
// Pipelined control unit (gen2): decode in D, control piped through E, MEM_STAGES M stages and W.
// Optional macro CTRL_UNDEF_TRAP_EN adds the UndefD output for unimplemented encodings.
module ctrl_unit_gen2 #(
   parameter int unsigned MEM_STAGES = 1,
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned ALUCTL_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [27:0]         InstrD,
   input  logic [3:0]          ALUFlagsE,
   input  logic                FlushE,
   output logic [1:0]          RegSrcD,
   output logic [1:0]          ImmSrcD,
   output logic                ALUSrcE,
   output logic [ALUCTL_W-1:0] ALUControlE,
   output logic                MulE,
   output logic                BusyE,
   output logic                BranchTakenE,
   output logic                MemtoRegE,
   output logic                MemWriteM,
   output logic                RegWriteM,
   output logic                MemtoRegW,
   output logic                RegWriteW,
   output logic                PCSrcW,
   output logic                PCWrPendingF,
`ifdef CTRL_UNDEF_TRAP_EN
   output logic                UndefD,
`endif
   output logic [3:0]          FlagsE
);

   localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   typedef struct packed {
      logic [3:0]          cond;
      logic [1:0]          flagWrite;
      logic                branch;
      logic                memWrite;
      logic                regWrite;
      logic                pcSrc;
      logic                memtoReg;
      logic                mul;
      logic                aluSrc;
      logic [ALUCTL_W-1:0] aluCtl;
   } ctlE_t;

   typedef struct packed {
      logic regWrite;
      logic memtoReg;
      logic pcSrc;
   } ctlM_t;

   // InstrD holds instruction bits [31:4], so instruction bit b sits at InstrD[b-4].
   logic [3:0] condD, cmdD, rdD;
   logic [1:0] opD;
   logic       immBitD, sBitD, isMulD;

   assign condD   = InstrD[27:24];
   assign opD     = InstrD[23:22];
   assign immBitD = InstrD[21];
   assign cmdD    = InstrD[20:17];
   assign sBitD   = InstrD[16];
   assign rdD     = InstrD[11:8];
   assign isMulD  = (opD == 2'b00) && (InstrD[23:18] == 6'b000000) && (InstrD[3:0] == 4'b1001);

   logic unusedInstr;
   assign unusedInstr = ^{InstrD[15:12], InstrD[7:4]};

   logic [1:0]          regSrcD, immSrcD, flagWriteD;
   logic                aluSrcD, branchD, memWriteD, regWriteD, memtoRegD, mulD, pcSrcD;
   logic                undefD, dpS, cvOp;
   logic [ALUCTL_W-1:0] aluCtlD;

   always_comb begin
      regSrcD    = 2'b00;
      immSrcD    = 2'b00;
      flagWriteD = 2'b00;
      aluSrcD    = 1'b0;
      branchD    = 1'b0;
      memWriteD  = 1'b0;
      regWriteD  = 1'b0;
      memtoRegD  = 1'b0;
      mulD       = 1'b0;
      undefD     = 1'b0;
      dpS        = 1'b0;
      cvOp       = 1'b0;
      aluCtlD    = '0;
      unique case (opD)
         2'b00: begin
            if (isMulD) begin
               regWriteD  = 1'b1;
               mulD       = 1'b1;
               aluCtlD    = ALUCTL_W'(8);
               flagWriteD = {sBitD, 1'b0};
            end else begin
               aluSrcD   = immBitD;
               regWriteD = 1'b1;
               dpS       = sBitD;
               case (cmdD)
                  4'b0100: begin aluCtlD = ALUCTL_W'(0); cvOp = 1'b1; end
                  4'b0010: begin aluCtlD = ALUCTL_W'(1); cvOp = 1'b1; end
                  4'b0000: aluCtlD = ALUCTL_W'(2);
                  4'b1100: aluCtlD = ALUCTL_W'(3);
                  4'b0001: aluCtlD = ALUCTL_W'(4);
                  4'b1110: aluCtlD = ALUCTL_W'(5);
                  4'b1101: aluCtlD = ALUCTL_W'(6);
                  4'b1111: aluCtlD = ALUCTL_W'(7);
                  4'b1010: begin
                     aluCtlD   = ALUCTL_W'(1);
                     cvOp      = 1'b1;
                     regWriteD = 1'b0;
                     dpS       = 1'b1;
                  end
                  4'b1000: begin
                     aluCtlD   = ALUCTL_W'(2);
                     regWriteD = 1'b0;
                     dpS       = 1'b1;
                  end
                  default: begin
                     regWriteD = 1'b0;
                     dpS       = 1'b0;
                     undefD    = 1'b1;
                  end
               endcase
               flagWriteD = {dpS, dpS & cvOp};
            end
         end
         2'b01: begin
            immSrcD = 2'b01;
            aluSrcD = 1'b1;
            if (sBitD) begin
               memtoRegD = 1'b1;
               regWriteD = 1'b1;
            end else begin
               regSrcD   = 2'b10;
               memWriteD = 1'b1;
            end
         end
         2'b10: begin
            regSrcD = 2'b01;
            immSrcD = 2'b10;
            aluSrcD = 1'b1;
            branchD = 1'b1;
         end
         default: undefD = 1'b1;
      endcase
   end

   assign pcSrcD  = ((rdD == 4'hF) & regWriteD & ~mulD) | branchD;
   assign RegSrcD = regSrcD;
   assign ImmSrcD = immSrcD;

`ifdef CTRL_UNDEF_TRAP_EN
   assign UndefD = undefD;
`else
   logic unusedUndef;
   assign unusedUndef = undefD;
`endif

   ctlE_t          eQ, eD;
   logic [CntW-1:0] cntQ, cntD;
   logic [3:0]     flagsQ, flagsD;
   logic           condExE;

   assign BusyE = (cntQ != '0);

   // Flush beats a busy hold, so a flushed MUL is dropped mid-flight.
   always_comb begin
      eD = eQ;
      if (FlushE || !BusyE) begin
         eD.cond      = condD;
         eD.flagWrite = flagWriteD;
         eD.branch    = branchD;
         eD.memWrite  = memWriteD;
         eD.regWrite  = regWriteD;
         eD.pcSrc     = pcSrcD;
         eD.memtoReg  = memtoRegD;
         eD.mul       = mulD;
         eD.aluSrc    = aluSrcD;
         eD.aluCtl    = aluCtlD;
      end
      if (FlushE) begin
         eD.flagWrite = 2'b00;
         eD.branch    = 1'b0;
         eD.memWrite  = 1'b0;
         eD.regWrite  = 1'b0;
         eD.pcSrc     = 1'b0;
         eD.memtoReg  = 1'b0;
         eD.mul       = 1'b0;
      end
   end

   always_comb begin
      cntD = '0;
      if (FlushE) cntD = '0;
      else if (BusyE) cntD = cntQ - CntW'(1);
      else if (mulD) cntD = CntW'(MUL_LAT - 1);
   end

   logic flagN, flagZ, flagC, flagV;
   assign {flagN, flagZ, flagC, flagV} = flagsQ;

   always_comb begin
      condExE = 1'b0;
      case (eQ.cond)
         4'b0000: condExE = flagZ;
         4'b0001: condExE = ~flagZ;
         4'b0010: condExE = flagC;
         4'b0011: condExE = ~flagC;
         4'b0100: condExE = flagN;
         4'b0101: condExE = ~flagN;
         4'b0110: condExE = flagV;
         4'b0111: condExE = ~flagV;
         4'b1000: condExE = flagC & ~flagZ;
         4'b1001: condExE = ~flagC | flagZ;
         4'b1010: condExE = (flagN == flagV);
         4'b1011: condExE = (flagN != flagV);
         4'b1100: condExE = ~flagZ & (flagN == flagV);
         4'b1101: condExE = flagZ | (flagN != flagV);
         default: condExE = 1'b1;
      endcase
   end

   always_comb begin
      flagsD = flagsQ;
      if (eQ.flagWrite[1] && condExE && !BusyE) flagsD[3:2] = ALUFlagsE[3:2];
      if (eQ.flagWrite[0] && condExE && !BusyE) flagsD[1:0] = ALUFlagsE[1:0];
   end

   // A busy MUL sends an all-zero bubble into M.
   ctlM_t mIn;
   logic  memWriteIn;
   always_comb begin
      mIn.regWrite = eQ.regWrite & condExE & ~BusyE;
      mIn.memtoReg = eQ.memtoReg & ~BusyE;
      mIn.pcSrc    = eQ.pcSrc & condExE & ~BusyE;
      memWriteIn   = eQ.memWrite & condExE & ~BusyE;
   end

   ctlM_t mQ [MEM_STAGES];
   ctlM_t wQ;
   logic  memWriteMQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         eQ         <= '0;
         cntQ       <= '0;
         flagsQ     <= '0;
         memWriteMQ <= 1'b0;
         wQ         <= '0;
         for (int unsigned i = 0; i < MEM_STAGES; i++) mQ[i] <= '0;
      end else begin
         eQ         <= eD;
         cntQ       <= cntD;
         flagsQ     <= flagsD;
         memWriteMQ <= memWriteIn;
         mQ[0]      <= mIn;
         for (int unsigned i = 1; i < MEM_STAGES; i++) mQ[i] <= mQ[i-1];
         wQ         <= mQ[MEM_STAGES-1];
      end
   end

   always_comb begin
      PCWrPendingF = pcSrcD | eQ.pcSrc;
      for (int unsigned i = 0; i < MEM_STAGES; i++) PCWrPendingF = PCWrPendingF | mQ[i].pcSrc;
   end

   assign ALUSrcE      = eQ.aluSrc;
   assign ALUControlE  = eQ.aluCtl;
   assign MulE         = eQ.mul;
   assign MemtoRegE    = eQ.memtoReg;
   assign BranchTakenE = eQ.branch & condExE & ~BusyE;
   assign FlagsE       = flagsQ;
   assign MemWriteM    = memWriteMQ;
   assign RegWriteM    = mQ[0].regWrite;
   assign MemtoRegW    = wQ.memtoReg;
   assign RegWriteW    = wQ.regWrite;
   assign PCSrcW       = wQ.pcSrc;

endmodule

// File: tb/tb_ctrl_unit_gen2.sv
// Directed bench for ctrl_unit_gen2 with MEM_STAGES=3, MUL_LAT=3 (default build, no UndefD).
module tb_ctrl_unit_gen2;

   localparam logic [31:0] NOP   = 32'hEC000000;
   localparam logic [31:0] ADDS  = 32'hE0921003;
   localparam logic [31:0] BEQ   = 32'h0A000000;
   localparam logic [31:0] LDR   = 32'hE5921000;
   localparam logic [31:0] STR   = 32'hE5821000;
   localparam logic [31:0] SUBS  = 32'hE0511002;
   localparam logic [31:0] CMPEQ = 32'h01510002;
   localparam logic [31:0] MVN   = 32'hE1E00000;
   localparam logic [31:0] MUL   = 32'hE0000291;
   localparam logic [31:0] MOVPC = 32'hE1A0F000;
   localparam logic [31:0] RSBPC = 32'hE060F000;

   logic       clk = 1'b0;
   logic       reset, FlushE;
   logic [27:0] InstrD;
   logic [3:0] ALUFlagsE, FlagsE, ALUControlE;
   logic [1:0] RegSrcD, ImmSrcD;
   logic       ALUSrcE, MulE, BusyE, BranchTakenE, MemtoRegE, MemWriteM, RegWriteM;
   logic       MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ctrl_unit_gen2 #(
      .MEM_STAGES(3),
      .MUL_LAT   (3),
      .ALUCTL_W  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .InstrD      (InstrD),
      .ALUFlagsE   (ALUFlagsE),
      .FlushE      (FlushE),
      .RegSrcD     (RegSrcD),
      .ImmSrcD     (ImmSrcD),
      .ALUSrcE     (ALUSrcE),
      .ALUControlE (ALUControlE),
      .MulE        (MulE),
      .BusyE       (BusyE),
      .BranchTakenE(BranchTakenE),
      .MemtoRegE   (MemtoRegE),
      .MemWriteM   (MemWriteM),
      .RegWriteM   (RegWriteM),
      .MemtoRegW   (MemtoRegW),
      .RegWriteW   (RegWriteW),
      .PCSrcW      (PCSrcW),
      .PCWrPendingF(PCWrPendingF),
      .FlagsE      (FlagsE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setInstr(input logic [31:0] ins);
      InstrD = ins[31:4];
      #1;
   endtask

   task automatic checkZero(input string tag);
      chk({tag, "_e"}, {23'd0, ALUSrcE, ALUControlE, MulE, BusyE, BranchTakenE, MemtoRegE}, 0);
      chk({tag, "_mw"}, {26'd0, MemWriteM, RegWriteM, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF},
          0);
      chk({tag, "_flags"}, {28'd0, FlagsE}, 0);
      chk({tag, "_dec"}, {28'd0, RegSrcD, ImmSrcD}, 0);
   endtask

   initial begin
      reset = 1'b1;
      FlushE = 1'b0;
      ALUFlagsE = 4'b0000;
      setInstr(NOP);
      tick();
      tick();
      checkZero("reset_init");
      reset = 1'b0;

      // ADDS sets Z, BEQ then resolves taken
      setInstr(ADDS);
      tick();
      chk("adds_aluctl", {28'd0, ALUControlE}, 0);
      chk("adds_busy", {31'd0, BusyE}, 0);
      ALUFlagsE = 4'b0100;
      setInstr(BEQ);
      chk("beq_regsrc", {30'd0, RegSrcD}, 1);
      chk("beq_immsrc", {30'd0, ImmSrcD}, 2);
      chk("beq_pend_d", {31'd0, PCWrPendingF}, 1);
      tick();
      chk("adds_flags", {28'd0, FlagsE}, 32'h4);
      chk("beq_taken", {31'd0, BranchTakenE}, 1);
      chk("beq_pend_e", {31'd0, PCWrPendingF}, 1);
      chk("adds_regwm", {31'd0, RegWriteM}, 1);
      chk("beq_alusrc", {31'd0, ALUSrcE}, 1);
      ALUFlagsE = 4'b0000;
      setInstr(NOP);
      tick();
      chk("beq_taken_gone", {31'd0, BranchTakenE}, 0);
      chk("beq_pend_m1", {31'd0, PCWrPendingF}, 1);
      chk("beq_regwm", {31'd0, RegWriteM}, 0);
      tick();
      chk("beq_pend_m2", {31'd0, PCWrPendingF}, 1);
      tick();
      chk("beq_pend_m3", {31'd0, PCWrPendingF}, 1);
      chk("adds_regww", {31'd0, RegWriteW}, 1);
      chk("adds_pcsrcw", {31'd0, PCSrcW}, 0);
      tick();
      chk("beq_pcsrcw", {31'd0, PCSrcW}, 1);
      chk("beq_pend_w", {31'd0, PCWrPendingF}, 0);
      chk("beq_regww", {31'd0, RegWriteW}, 0);

      // LDR then STR through three M stages
      setInstr(LDR);
      chk("ldr_immsrc", {30'd0, ImmSrcD}, 1);
      chk("ldr_regsrc", {30'd0, RegSrcD}, 0);
      tick();
      chk("ldr_memtoreg_e", {31'd0, MemtoRegE}, 1);
      chk("ldr_alusrc", {31'd0, ALUSrcE}, 1);
      setInstr(STR);
      chk("str_regsrc", {30'd0, RegSrcD}, 2);
      tick();
      chk("ldr_regwm", {31'd0, RegWriteM}, 1);
      chk("ldr_memwm", {31'd0, MemWriteM}, 0);
      chk("str_memtoreg_e", {31'd0, MemtoRegE}, 0);
      setInstr(NOP);
      tick();
      chk("str_memwm", {31'd0, MemWriteM}, 1);
      chk("str_regwm", {31'd0, RegWriteM}, 0);
      tick();
      chk("ldr_regww_early", {31'd0, RegWriteW}, 0);
      tick();
      chk("ldr_regww", {31'd0, RegWriteW}, 1);
      chk("ldr_memtoregw", {31'd0, MemtoRegW}, 1);
      tick();
      chk("str_regww", {31'd0, RegWriteW}, 0);
      chk("str_memtoregw", {31'd0, MemtoRegW}, 0);

      // SUBS clears Z, then CMPEQ must not execute
      setInstr(SUBS);
      tick();
      chk("subs_aluctl", {28'd0, ALUControlE}, 1);
      ALUFlagsE = 4'b0010;
      setInstr(CMPEQ);
      tick();
      chk("subs_flags", {28'd0, FlagsE}, 32'h2);
      chk("cmp_aluctl", {28'd0, ALUControlE}, 1);
      chk("subs_regwm", {31'd0, RegWriteM}, 1);
      ALUFlagsE = 4'b1111;
      setInstr(MVN);
      tick();
      chk("cmp_flags_held", {28'd0, FlagsE}, 32'h2);
      chk("cmp_regwm", {31'd0, RegWriteM}, 0);
      chk("mvn_aluctl", {28'd0, ALUControlE}, 7);
      ALUFlagsE = 4'b0000;
      setInstr(NOP);
      tick();

      // MUL occupies E for three cycles
      setInstr(MUL);
      tick();
      chk("mul_busy0", {31'd0, BusyE}, 1);
      chk("mul_mule", {31'd0, MulE}, 1);
      chk("mul_aluctl", {28'd0, ALUControlE}, 8);
      setInstr(NOP);
      tick();
      chk("mul_busy1", {31'd0, BusyE}, 1);
      chk("mul_bubble1", {31'd0, RegWriteM}, 0);
      tick();
      chk("mul_busy2", {31'd0, BusyE}, 0);
      chk("mul_mule_last", {31'd0, MulE}, 1);
      chk("mul_bubble2", {31'd0, RegWriteM}, 0);
      tick();
      chk("mul_regwm", {31'd0, RegWriteM}, 1);
      chk("mul_mule_gone", {31'd0, MulE}, 0);
      tick();
      tick();
      chk("mul_regww_early", {31'd0, RegWriteW}, 0);
      tick();
      chk("mul_regww", {31'd0, RegWriteW}, 1);

      // FlushE during busy drops the MUL
      setInstr(MUL);
      tick();
      chk("flush_busy_pre", {31'd0, BusyE}, 1);
      FlushE = 1'b1;
      setInstr(NOP);
      tick();
      FlushE = 1'b0;
      chk("flush_busy", {31'd0, BusyE}, 0);
      chk("flush_mule", {31'd0, MulE}, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("flush_regwm_%0d", k), {31'd0, RegWriteM}, 0);
         chk($sformatf("flush_regww_%0d", k), {31'd0, RegWriteW}, 0);
      end

      // Reset while a MUL is busy
      setInstr(MUL);
      tick();
      chk("rstmul_busy_pre", {31'd0, BusyE}, 1);
      reset = 1'b1;
      setInstr(NOP);
      tick();
      chk("rstmul_busy", {31'd0, BusyE}, 0);
      tick();
      checkZero("reset_mid");
      reset = 1'b0;

      // Rd=PC write pending from D; unimplemented opcode writes nothing
      setInstr(MOVPC);
      chk("movpc_pend", {31'd0, PCWrPendingF}, 1);
      setInstr(RSBPC);
      chk("rsb_pend", {31'd0, PCWrPendingF}, 0);
      tick();
      setInstr(NOP);
      tick();
      chk("rsb_regwm", {31'd0, RegWriteM}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ctrl_unit_gen2.md
Name: ctrl_unit_gen2

Overview:
Second-generation pipelined control unit for the 5-stage ARM core. It decodes InstrD and pipes control through Execute, a parametrised chain of Memory stages and Writeback. It adds:
- an extended DP set (MOV, MVN, CMP, TST);
- a multi-cycle MUL with an Execute-stage busy counter;
- a conditional flags register held during stalls;
- a PC-write-pending hazard output sized to the pipeline depth.

Parameters:
MEM_STAGES, 1, number of register stages between E and W (>=1); W lags E by MEM_STAGES+1 cycles.
MUL_LAT, 3, cycles a MUL occupies E (>=1).
ALUCTL_W, 4, width of ALUControlE (>=4).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
InstrD  in  28  instruction bits [31:4] in Decode
ALUFlagsE  in  4  ALU {N,Z,C,V} from Execute
FlushE  in  1  clear D/E control register
RegSrcD  out  2  register-source select
ImmSrcD  out  2  immediate-extend select
ALUSrcE  out  1  ALU B = immediate
ALUControlE  out  ALUCTL_W  ALU operation
MulE  out  1  multiplier select in E
BusyE  out  1  E occupied by MUL; hazard unit stalls F/D
BranchTakenE  out  1  conditional branch taken
MemtoRegE  out  1  load in E (load-use hazard)
MemWriteM  out  1  store enable, first M stage
RegWriteM  out  1  reg write, first M stage
MemtoRegW  out  1  W result select
RegWriteW  out  1  register-file write
PCSrcW  out  1  W writes PC
PCWrPendingF  out  1  PC write in flight
FlagsE  out  4  architectural flags register

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All pipeline registers, the flags register and the busy counter clear to 0, so every output reads 0 after reset.
- Main decode on InstrD[27:26]:
  - 00 with [27:22]=000000 and [7:4]=1001: MUL, giving RegWrite=1, ALUSrc=0, MulD=1, ALUControl=8.
  - Other 00: DP; ALUSrc=[25], RegWrite=1, ALUOp=1.
  - 01: [20]=1 LDR, [20]=0 STR. Control as in gen1: LDR sets ImmSrc=01, ALUSrc=1, MemtoReg=1, RegWrite=1; STR sets RegSrc=10, ImmSrc=01, ALUSrc=1, MemWrite=1.
  - 10: B, giving RegSrc=01, ImmSrc=10, ALUSrc=1, Branch=1.
  - 11: unimplemented.
- ALU decode on [24:21]:
  - ADD 0100->0, SUB 0010->1, AND 0000->2, ORR 1100->3, EOR 0001->4, BIC 1110->5, MOV 1101->6, MVN 1111->7.
  - CMP 1010->1 and TST 1000->2, both with RegWrite forced 0 and S forced 1.
  - Other opcodes are unimplemented.
  - Non-DP instructions use ADD.
- Flag writes:
  - FlagWrite[1] (NZ) = S.
  - FlagWrite[0] (CV) = S & (ADD|SUB|CMP).
  - MUL with S=1 writes NZ only.
- PCSrcD = (Rd=[15:12]=1111 & RegWrite & !MUL) | Branch.
- D->E register: loads every cycle unless BusyE.
  - FlushE clears the control fields (FlagWrite, Branch, MemWrite, RegWrite, PCSrc, MemtoReg, Mul).
  - FlushE overrides BusyE and aborts the busy counter.
- MUL in E:
  - Counter loads MUL_LAT-1 on entry; BusyE = (count!=0).
  - While BusyE: the E register holds; a bubble (all-zero control) enters M; flags are not written.
  - The MUL's gated controls and flags advance on the cycle count=0.
  - MUL_LAT=1 means no busy cycles.
- Condition unit: CondExE is evaluated from CondE against FlagsE (the standard 15 ARM conditions; 1111 means always).
  - Flags register: FlagsE[3:2] <= ALUFlagsE[3:2] when FlagWriteE[1] & CondExE & !BusyE; FlagsE[1:0] likewise with FlagWriteE[0].
  - RegWrite, MemWrite and PCSrc are gated by CondExE into M.
  - BranchTakenE = BranchE & CondExE & !BusyE.
- M chain: MEM_STAGES stages, then one W register. MemWriteM and RegWriteM come from M stage 1.
- PCWrPendingF = PCSrcD | PCSrcE | OR of PCSrc over all M stages.
- Reset mid-MUL: the counter clears and BusyE falls on the next cycle.

Optional Feature:
CTRL_UNDEF_TRAP_EN:
- Defined: adds output UndefD (1 bit). It is asserted combinationally for op 11 or an unimplemented DP opcode. That instruction's RegWrite, MemWrite, Branch, PCSrc and FlagWrite are forced 0.
- Undefined: no UndefD port. Unimplemented encodings still decode as a NOP with all writes 0.

Test Plan:
- Reset: hold reset 2 cycles mid-stream -> all outputs 0 on the cycle after; FlagsE=0000.
- ADDS then BEQ, with ALUFlagsE=0100 from the ADDS (Z=1) -> FlagsE=0100 after E; BranchTakenE=1 when BEQ is in E; PCWrPendingF high from D until PCSrc leaves the last M stage.
- MUL with MUL_LAT=3 -> BusyE high 2 cycles; M receives 2 bubbles; RegWriteW=1 exactly MEM_STAGES+3 cycles after the MUL enters E.
- CMP (1010, S=1) with condition EQ and Z=0 -> CondExE=0; no flag update and RegWriteM=0.
- MEM_STAGES=3 with an LDR -> RegWriteM at E+1, MemtoRegW=1 and RegWriteW=1 at E+4.
- FlushE asserted during a BusyE cycle -> BusyE=0 next cycle; the MUL never reaches W.
